// File: rtl/led_frame_writer.sv
// led_frame_writer: turns a 24-bit RGB pixel stream into per-plane writes
// of {r0,g0,b0,r1,g1,b1} words in the LED frame BRAM.
module led_frame_writer #(
   parameter int N_ROWS_MAX       = 64,
   parameter int N_COLS_MAX       = 256,
   parameter int BITDEPTH_MAX     = 8,
   parameter int CTRL_REG_WIDTH   = 32,
   parameter int MEM_W_ADDR_WIDTH = $clog2(N_ROWS_MAX*N_COLS_MAX)-1,
   parameter int MEM_W_DATA_WIDTH = 6
) (
   input  logic                              clk,
   input  logic                              ctrl_rst_n,
   input  logic                              ctrl_en,
   input  logic [CTRL_REG_WIDTH-1:0]         ctrl_n_rows,
   input  logic [CTRL_REG_WIDTH-1:0]         ctrl_n_cols,
   input  logic [CTRL_REG_WIDTH-1:0]         ctrl_bitdepth,
   input  logic [CTRL_REG_WIDTH-1:0]         ctrl_buffer,
   input  logic [23:0]                       s_pixel_data,
   input  logic                              s_pixel_sof,
   input  logic                              s_pixel_valid,
   output logic                              s_pixel_ready,
   output logic                              mem_clk,
   output logic                              mem_en,
   output logic [1:0]                        mem_we,
   output logic                              mem_buffer,
   output logic [MEM_W_ADDR_WIDTH-1:0]       mem_addr,
   output logic [$clog2(BITDEPTH_MAX)-1:0]   mem_bit,
   output logic [MEM_W_DATA_WIDTH-1:0]       mem_dout,
   output logic                              frame_done,
   output logic                              err_sof
);
   localparam int BW  = $clog2(BITDEPTH_MAX);
   localparam int BDW = BW + 1;
   localparam int CW  = CTRL_REG_WIDTH;
   typedef enum logic [1:0] {WAIT_SOF, IDLE, WRITE} state_t;
   state_t state;
   logic [CW-1:0] n_rows, n_cols, half, row, col, bd_c;
   logic [BDW-1:0] bitdepth;
   logic [BW-1:0] p;
   logic [23:0] pix;
   logic [7:0] r_c, g_c, b_c;
   logic [2:0] idx, rgb;
   logic drop, accept, cfg_ok, wr, top, last_plane, last_col, last_pix, abort;
   logic unused_ok;
   assign unused_ok = ^ctrl_buffer[CW-1:1];
   always_comb begin
      s_pixel_ready = ctrl_rst_n && ctrl_en && state != WRITE;
      accept = s_pixel_valid && s_pixel_ready;
      cfg_ok = ctrl_n_rows >= CW'(2) && ctrl_n_cols != '0;
      bd_c = ctrl_bitdepth == '0 ? CW'(1) : ctrl_bitdepth > CW'(BITDEPTH_MAX) ? CW'(BITDEPTH_MAX) : ctrl_bitdepth;
      wr = state == WRITE;
      top = row < half;
      last_plane = {1'b0, p} == bitdepth - BDW'(1);
      last_col = col == n_cols - CW'(1);
      last_pix = last_col && row == n_rows - CW'(1);
      abort = drop || !ctrl_en;
      // planes are MSB-aligned: plane 0 of a 2-plane frame is colour bit 6
      idx = 3'(CW'(8) - CW'(bitdepth) + CW'(p));
      {r_c, g_c, b_c} = pix;
      rgb = {r_c[idx], g_c[idx], b_c[idx]};
      mem_clk = clk;
      mem_we = wr ? (top ? 2'b10 : 2'b01) : 2'b00;
      mem_en = |mem_we;
      mem_addr = wr ? MEM_W_ADDR_WIDTH'((top ? row : row - half) * n_cols + col) : '0;
      mem_bit = wr ? p : '0;
      mem_dout = !wr ? '0 : top ? {rgb, 3'b000} : {3'b000, rgb};
   end
   always_ff @(posedge clk) begin
      if (!ctrl_rst_n) begin
         state <= WAIT_SOF;
         n_rows <= '0;
         n_cols <= '0;
         half <= '0;
         row <= '0;
         col <= '0;
         bitdepth <= '0;
         p <= '0;
         pix <= '0;
         drop <= 1'b0;
         mem_buffer <= 1'b0;
         frame_done <= 1'b0;
         err_sof <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         err_sof <= accept && s_pixel_sof && state == IDLE;
         case (state)
            WAIT_SOF, IDLE: begin
               if (accept && s_pixel_sof && cfg_ok) begin
                  n_rows <= ctrl_n_rows;
                  n_cols <= ctrl_n_cols;
                  half <= ctrl_n_rows >> 1;
                  bitdepth <= BDW'(bd_c);
                  mem_buffer <= ctrl_buffer[0];
                  row <= '0;
                  col <= '0;
               end
               if (accept && (s_pixel_sof ? cfg_ok : state == IDLE)) begin
                  pix <= s_pixel_data;
                  p <= '0;
                  drop <= 1'b0;
                  state <= WRITE;
               end else if (!ctrl_en || (accept && s_pixel_sof)) begin
                  state <= WAIT_SOF;
               end
            end
            WRITE: begin
               drop <= abort;
               p <= last_plane ? '0 : p + 1'b1;
               if (last_plane) begin
                  col <= last_col ? '0 : col + 1'b1;
                  row <= last_col ? row + 1'b1 : row;
                  // an enable drop during the pixel aborts the frame without frame_done
                  frame_done <= last_pix && !abort;
                  state <= (last_pix || abort) ? WAIT_SOF : IDLE;
               end
            end
            default: state <= WAIT_SOF;
         endcase
      end
   end
endmodule

// File: tb/tb_led_frame_writer.sv
// tb_led_frame_writer: scoreboard of expected BRAM writes plus table-driven
// frame vectors and hand-written corner-case sequences.
module tb_led_frame_writer;
   logic clk, ctrl_rst_n, ctrl_en, s_pixel_sof, s_pixel_valid, s_pixel_ready;
   logic [31:0] ctrl_n_rows, ctrl_n_cols, ctrl_bitdepth, ctrl_buffer;
   logic [23:0] s_pixel_data;
   logic mem_clk, mem_en, mem_buffer, frame_done, err_sof;
   logic [1:0] mem_we;
   logic [12:0] mem_addr;
   logic [2:0] mem_bit;
   logic [5:0] mem_dout;

   led_frame_writer dut (
      .clk(clk), .ctrl_rst_n(ctrl_rst_n), .ctrl_en(ctrl_en),
      .ctrl_n_rows(ctrl_n_rows), .ctrl_n_cols(ctrl_n_cols),
      .ctrl_bitdepth(ctrl_bitdepth), .ctrl_buffer(ctrl_buffer),
      .s_pixel_data(s_pixel_data), .s_pixel_sof(s_pixel_sof),
      .s_pixel_valid(s_pixel_valid), .s_pixel_ready(s_pixel_ready),
      .mem_clk(mem_clk), .mem_en(mem_en), .mem_we(mem_we),
      .mem_buffer(mem_buffer), .mem_addr(mem_addr), .mem_bit(mem_bit),
      .mem_dout(mem_dout), .frame_done(frame_done), .err_sof(err_sof)
   );

   typedef struct {
      logic [12:0] addr;
      logic [2:0]  pl;
      logic [1:0]  we;
      logic [5:0]  dout;
      logic        bsel;
   } exp_t;
   typedef struct {
      logic [23:0] data;
      logic [12:0] addr;
      logic [1:0]  we;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[7];
   int tests = 0, fails = 0;
   int cyc = 0, wr_count = 0, last_wr_cyc = 0, fd_cyc = 0, fd_count = 0, err_count = 0;
   int m_bd = 2;
   logic m_buf = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we != 2'b00) begin
         wr_count++;
         last_wr_cyc = cyc;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL write: unexpected addr %0h bit %0d we %b dout %b, required no write", mem_addr, mem_bit, mem_we, mem_dout);
         end else begin
            mon_e = sb.pop_front();
            if ({mem_addr, mem_bit, mem_we, mem_dout, mem_buffer, mem_en} !== {mon_e.addr, mon_e.pl, mon_e.we, mon_e.dout, mon_e.bsel, 1'b1}) begin
               fails++;
               $display("FAIL write: got addr %0h bit %0d we %b dout %b buf %b en %b, required addr %0h bit %0d we %b dout %b buf %b en 1",
                        mem_addr, mem_bit, mem_we, mem_dout, mem_buffer, mem_en, mon_e.addr, mon_e.pl, mon_e.we, mon_e.dout, mon_e.bsel);
            end
         end
      end
      if (frame_done === 1'b1) begin
         fd_count++;
         fd_cyc = cyc;
      end
      if (err_sof === 1'b1) err_count++;
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] dout_of(logic [23:0] d, int p, logic [1:0] we);
      logic [7:0] r, g, b;
      logic [2:0] rgb;
      int i;
      i = 8 - m_bd + p;
      {r, g, b} = d;
      rgb = {r[i], g[i], b[i]};
      return we == 2'b10 ? {rgb, 3'b000} : {3'b000, rgb};
   endfunction

   task automatic push_px(logic [12:0] a, logic [1:0] we, logic [23:0] d, int np);
      for (int p = 0; p < np; p++) sb.push_back('{a, 3'(p), we, dout_of(d, p, we), m_buf});
   endtask

   task automatic send(logic [23:0] d, logic sof);
      int n = 0;
      s_pixel_data = d;
      s_pixel_sof = sof;
      s_pixel_valid = 1'b1;
      @(negedge clk);
      while (s_pixel_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: ready 0 for 50 cycles, required 1");
      end
      @(posedge clk);
      #1;
      s_pixel_valid = 1'b0;
      s_pixel_sof = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain_outstanding", sb.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int w0, f0, e0, hi;
      ctrl_rst_n = 1'b0; ctrl_en = 1'b1; ctrl_n_rows = 4; ctrl_n_cols = 2;
      ctrl_bitdepth = 2; ctrl_buffer = 0;
      s_pixel_data = '0; s_pixel_sof = 1'b0; s_pixel_valid = 1'b0;
      vecs = '{'{$urandom, 13'd1, 2'b10}, '{$urandom, 13'd2, 2'b10}, '{$urandom, 13'd3, 2'b10},
               '{$urandom, 13'd0, 2'b01}, '{24'hFFFFFF, 13'd1, 2'b01}, '{$urandom, 13'd2, 2'b01},
               '{$urandom, 13'd3, 2'b01}};
      idle_cycles(3);
      @(negedge clk);
      check("rst_ready", s_pixel_ready, 0);
      check("rst_outputs", {mem_we, mem_addr, mem_bit, mem_dout, mem_buffer, frame_done, err_sof}, 0);
      check("mem_clk", mem_clk, clk);
      @(posedge clk); #1;
      ctrl_rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", s_pixel_ready, 1);
      @(posedge clk); #1;

      // first SOF pixel, exact cycle-by-cycle view
      m_bd = 2; m_buf = 1'b0;
      sb.push_back('{13'd0, 3'd0, 2'b10, 6'b110000, 1'b0});
      sb.push_back('{13'd0, 3'd1, 2'b10, 6'b101000, 1'b0});
      send(24'hC04080, 1'b1);
      @(negedge clk);
      check("p0_we_addr_bit", {mem_we, mem_addr, mem_bit}, {2'b10, 13'd0, 3'd0});
      check("p0_dout", mem_dout, 6'b110000);
      check("p0_ready", s_pixel_ready, 0);
      @(negedge clk);
      check("p1_bit_dout", {mem_bit, mem_dout}, {3'd1, 6'b101000});
      check("p1_ready", s_pixel_ready, 0);
      @(negedge clk);
      check("after_write_ready_we", {s_pixel_ready, mem_we}, {1'b1, 2'b00});
      @(posedge clk); #1;

      // rest of the 4x2 frame from the vector table
      f0 = fd_count;
      for (int i = 0; i < 7; i++) begin
         push_px(vecs[i].addr, vecs[i].we, vecs[i].data, m_bd);
         send(vecs[i].data, 1'b0);
      end
      drain();
      check("frame_done_count", fd_count - f0, 1);
      check("frame_done_timing", fd_cyc - last_wr_cyc, 1);
      check("frame_writes", wr_count, 16);

      // back in WAIT_SOF: pixels without SOF are swallowed
      w0 = wr_count;
      for (int i = 0; i < 3; i++) send($urandom, 1'b0);
      idle_cycles(6);
      check("no_sof_discard", wr_count - w0, 0);

      // mid-frame SOF resyncs to row 0 col 0
      f0 = fd_count; e0 = err_count;
      push_px(13'd0, 2'b10, 24'h123456, m_bd); send(24'h123456, 1'b1);
      push_px(13'd1, 2'b10, 24'hA5C30F, m_bd); send(24'hA5C30F, 1'b0);
      push_px(13'd2, 2'b10, 24'h5A3CF0, m_bd); send(24'h5A3CF0, 1'b0);
      push_px(13'd0, 2'b10, 24'h0F0F0F, m_bd); send(24'h0F0F0F, 1'b1);
      drain();
      check("err_sof_pulse", err_count - e0, 1);
      check("no_frame_done_resync", fd_count - f0, 0);

      // enable drop mid-pixel with 8 planes
      ctrl_en = 1'b0;
      idle_cycles(2);
      ctrl_en = 1'b1; ctrl_bitdepth = 8; m_bd = 8;
      push_px(13'd0, 2'b10, 24'h81C3E7, 8);
      send(24'h81C3E7, 1'b1);
      @(posedge clk); #1;
      ctrl_en = 1'b0;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (s_pixel_ready !== 1'b0) hi++;
      end
      @(posedge clk); #1;
      drain();
      check("ready_low_en_drop", hi, 0);
      ctrl_en = 1'b1;
      w0 = wr_count;
      send(24'h777777, 1'b0);
      idle_cycles(10);
      check("ignored_after_abort", wr_count - w0, 0);
      push_px(13'd0, 2'b10, 24'h3C5A96, 8);
      send(24'h3C5A96, 1'b1);
      drain();

      // reset during plane 3 of the next pixel
      push_px(13'd1, 2'b10, 24'hF1E2D3, 4);
      send(24'hF1E2D3, 1'b0);
      idle_cycles(3);
      ctrl_rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_rst_outputs", {mem_we, mem_addr, mem_bit, mem_dout, mem_buffer, frame_done, err_sof}, 0);
      check("mid_rst_ready", s_pixel_ready, 0);
      check("mid_rst_queue", sb.size(), 0);
      @(posedge clk); #1;
      ctrl_rst_n = 1'b1;
      ctrl_buffer = 1; ctrl_bitdepth = 0; ctrl_n_rows = 1; ctrl_n_cols = 1;
      w0 = wr_count;
      send(24'hFFFFFF, 1'b0);
      send(24'hFFFFFF, 1'b1);
      idle_cycles(6);
      check("post_rst_needs_valid_sof", wr_count - w0, 0);

      // 2x1 frame, bitdepth 0 clamps to one plane, buffer 1 held all frame
      ctrl_n_rows = 2; m_bd = 1; m_buf = 1'b1;
      f0 = fd_count;
      push_px(13'd0, 2'b10, 24'h80FF00, 1); send(24'h80FF00, 1'b1);
      ctrl_buffer = 0;
      push_px(13'd0, 2'b01, 24'h008080, 1); send(24'h008080, 1'b0);
      drain();
      check("buf1_frame_done", fd_count - f0, 1);
      check("buf1_latched", mem_buffer, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
